fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries; SHALL be a power of two, 2 to 16.
REQ-002 i_clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 i_reset  input  1  reset, asynchronous and active-low.
REQ-004 i_pc  input  32  current PC-register value from the PC stage.
REQ-005 i_instr  input  32  instruction-memory read data for i_pc, valid in the same cycle.
REQ-006 i_flush  input  1  redirect (taken branch or jump) this cycle; discards all queued and in-flight fetches.
REQ-007 i_id_ready  input  1  decode stage accepts the head entry this cycle.
REQ-008 o_pc_en  output  1  PC advance enable to the PC stage stall input (1 = load next PC, 0 = hold).
REQ-009 o_id_valid  output  1  head entry is valid for decode.
REQ-010 o_id_pc  output  32  PC of the head entry.
REQ-011 o_id_instr  output  32  instruction of the head entry.
REQ-012 o_count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-013 Storage SHALL be a circular buffer of DEPTH entries, each {pc[31:0], instr[31:0]}, with write and read pointers wrapping modulo DEPTH.
REQ-014 o_pc_en SHALL equal (o_count != DEPTH) OR i_flush; it SHALL NOT depend combinationally on i_id_ready.
REQ-015 Push condition: (o_count != DEPTH) AND NOT i_flush; on push {i_pc, i_instr} SHALL be written at the write pointer, and the write pointer SHALL advance by 1.
REQ-016 Pop condition: o_id_valid AND i_id_ready AND NOT i_flush; on pop the read pointer SHALL advance by 1.
REQ-017 Simultaneous push and pop SHALL leave o_count unchanged, including at count 1 and at count DEPTH-1.
REQ-018 When full (o_count == DEPTH), a pop SHALL proceed without a push; o_pc_en SHALL be 0 in that cycle, so the PC holds and the same fetch is presented again.
REQ-019 When empty, pop is impossible; a push in that cycle SHALL make the entry visible at the outputs in the next cycle, with no same-cycle bypass.
REQ-020 On i_flush the next-cycle state SHALL be: o_count = 0 and both pointers = 0. No push or pop SHALL occur in the flush cycle.
REQ-021 i_flush SHALL take priority over push, pop and full.
REQ-022 o_id_valid SHALL equal (o_count != 0).
REQ-023 o_id_pc and o_id_instr SHALL be driven combinationally from the read-pointer entry when o_id_valid is 1.
REQ-024 When o_id_valid is 0, o_id_pc SHALL be 32'h0000_0000 and o_id_instr SHALL be 32'h0000_0013 (NOP).
REQ-025 Fetch-to-decode latency SHALL be exactly 1 cycle when the queue is empty and decode is ready.

Reset
REQ-026 While i_reset is 0, o_count, both pointers and all entries SHALL be cleared immediately, without waiting for a clock edge; entries clear to pc 0, instr 32'h0000_0013.
REQ-027 During reset the outputs SHALL be: o_id_valid = 0, o_id_pc = 0, o_id_instr = 32'h0000_0013, o_count = 0, o_pc_en = 1.
REQ-028 Reset asserted mid-operation SHALL discard all entries; after release, the first push SHALL land in entry 0.

Verification
REQ-029 Reset release, i_pc = 0x0 then 0x4, i_instr = 0x00500093 then 0x00A00113, i_id_ready = 1 -> o_id_valid = 1 one cycle after each fetch; o_id_pc = 0x0 then 0x4; o_count stays 1.
REQ-030 i_id_ready = 0 for 5 cycles with PCs 0x0, 0x4, 0x8, 0xC, 0x10 -> o_count saturates at 4 and o_pc_en = 0 while full; head stays pc 0x0. Then raise i_id_ready -> entries pop in order 0x0, 0x4, 0x8, 0xC, and 0x10 is accepted after the first pop.
REQ-031 Queue holds 3 entries and i_flush = 1 with i_pc = 0x40 -> next cycle o_count = 0, o_id_valid = 0, o_id_instr = 0x00000013; o_pc_en = 1 in the flush cycle.
REQ-032 Queue full with i_flush = 1 and i_id_ready = 1 in the same cycle -> flush wins: no pop is recorded, o_pc_en = 1, and o_count = 0 next cycle.
REQ-033 Push and pop continuously for 10 cycles from o_count = 2 -> o_count constant at 2; pointers wrap past DEPTH-1 to 0; PC order preserved.
REQ-034 Assert i_reset = 0 asynchronously between clock edges with o_count = 3 -> o_count = 0 and o_id_valid = 0 immediately, before the next edge.

Source files
------------

// File: rtl/fetch_queue_if.sv
// ----------------------------------------------------------------------------
// fetch_queue_if
// Purpose : groups the fetch-side and decode-side signals of the fetch queue
//           into one bundle.
// Signals :
//   i_pc, i_instr   fetch address and the instruction-memory data for it
//   i_flush         redirect; drops every queued and in-flight fetch
//   i_id_ready      decode accepts the head entry this cycle
//   o_pc_en         PC advance enable back to the PC stage
//   o_id_valid      head entry valid for decode
//   o_id_pc         head entry PC
//   o_id_instr      head entry instruction (NOP when empty)
//   o_count         number of occupied entries
// Modports: master = fetch/decode environment, slave = the queue itself.
// ----------------------------------------------------------------------------
interface fetch_queue_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [31:0]      i_pc;
    logic [31:0]      i_instr;
    logic             i_flush;
    logic             i_id_ready;
    logic             o_pc_en;
    logic             o_id_valid;
    logic [31:0]      o_id_pc;
    logic [31:0]      o_id_instr;
    logic [CNT_W-1:0] o_count;

    modport master (
        output i_pc,
        output i_instr,
        output i_flush,
        output i_id_ready,
        input  o_pc_en,
        input  o_id_valid,
        input  o_id_pc,
        input  o_id_instr,
        input  o_count
    );

    modport slave (
        input  i_pc,
        input  i_instr,
        input  i_flush,
        input  i_id_ready,
        output o_pc_en,
        output o_id_valid,
        output o_id_pc,
        output o_id_instr,
        output o_count
    );
endinterface

// File: rtl/fetch_queue.sv
// ----------------------------------------------------------------------------
// fetch_queue
// Purpose : circular buffer of {pc, instr} pairs between the fetch stage and
//           the decode stage. Fetches are pushed whenever there is room, the
//           head entry is presented to decode, and a redirect empties the
//           queue in one cycle.
// Ports   :
//   i_clk     clock, all state updates on the rising edge
//   i_reset   asynchronous active-low reset, clears count, pointers and
//             every entry immediately
//   bus       fetch_queue_if slave modport (fetch inputs, decode outputs,
//             PC enable and occupancy)
// Parameter DEPTH: number of entries, power of two from 2 to 16.
// ----------------------------------------------------------------------------
module fetch_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic          i_clk,
    input  logic          i_reset,
    fetch_queue_if.slave  bus
);

    localparam int unsigned PTR_W     = $clog2(DEPTH);
    localparam int unsigned CNT_W     = $clog2(DEPTH) + 1;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    localparam entry_t ENTRY_RST = '{pc: 32'h0000_0000, instr: NOP_INSTR};

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    entry_t           mem_q [DEPTH];

    logic   full;
    logic   valid;
    logic   push;
    logic   pop;
    entry_t head;

    // Occupancy decode; flush overrides both push and pop.
    assign full  = (count_q == CNT_W'(DEPTH));
    assign valid = (count_q != '0);
    assign push  = !full && !bus.i_flush;
    assign pop   = valid && bus.i_id_ready && !bus.i_flush;

    // Next-state for pointers and count. Pointers wrap naturally since
    // DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Pointer and count registers.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; cleared to NOP entries on reset, untouched by flush
    // because a zero count already hides stale contents.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= ENTRY_RST;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= '{pc: bus.i_pc, instr: bus.i_instr};
        end
    end

    // Head entry is read straight from storage; empty queue shows a NOP.
    assign head = valid ? mem_q[rd_ptr_q] : ENTRY_RST;

    assign bus.o_id_valid = valid;
    assign bus.o_id_pc    = head.pc;
    assign bus.o_id_instr = head.instr;
    assign bus.o_count    = count_q;

    // The PC may advance whenever this fetch can be stored, or on a redirect
    // so the branch target is loaded. Decode readiness is deliberately not
    // part of this term, keeping the PC loop free of the decode path.
    assign bus.o_pc_en    = !full || bus.i_flush;

endmodule

// File: tb/tb_fetch_queue.sv
// ----------------------------------------------------------------------------
// tb_fetch_queue
// Purpose : directed self-checking bench for fetch_queue (DEPTH = 4).
// ----------------------------------------------------------------------------
module tb_fetch_queue;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_pass   = 0;

    fetch_queue_if #(.DEPTH(DEPTH)) bus ();

    fetch_queue #(.DEPTH(DEPTH)) u_dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return 32'hA000_0000 | pc;
    endfunction

    task automatic fetch(input logic [31:0] pc);
        bus.i_pc    = pc;
        bus.i_instr = instr_of(pc);
    endtask

    initial begin
        logic [31:0] exp_pc;

        rst_n          = 1'b0;
        bus.i_pc       = '0;
        bus.i_instr    = '0;
        bus.i_flush    = 1'b0;
        bus.i_id_ready = 1'b0;
        #3;
        check("rst_valid", 32'(bus.o_id_valid), 32'd0);
        check("rst_pc",    bus.o_id_pc,         32'd0);
        check("rst_instr", bus.o_id_instr,      NOP);
        check("rst_count", 32'(bus.o_count),    32'd0);
        check("rst_pc_en", 32'(bus.o_pc_en),    32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming with decode ready: one-cycle latency, count stays 1.
        bus.i_id_ready = 1'b1;
        bus.i_pc       = 32'h0;
        bus.i_instr    = 32'h0050_0093;
        #1;
        check("s1_no_bypass", 32'(bus.o_id_valid), 32'd0);
        check("s1_pc_en",     32'(bus.o_pc_en),    32'd1);
        step();
        check("s1_valid", 32'(bus.o_id_valid), 32'd1);
        check("s1_pc",    bus.o_id_pc,         32'h0);
        check("s1_instr", bus.o_id_instr,      32'h0050_0093);
        check("s1_count", 32'(bus.o_count),    32'd1);
        bus.i_pc    = 32'h4;
        bus.i_instr = 32'h00A0_0113;
        step();
        check("s2_valid", 32'(bus.o_id_valid), 32'd1);
        check("s2_pc",    bus.o_id_pc,         32'h4);
        check("s2_instr", bus.o_id_instr,      32'h00A0_0113);
        check("s2_count", 32'(bus.o_count),    32'd1);

        // Empty the queue.
        bus.i_flush    = 1'b1;
        bus.i_id_ready = 1'b0;
        step();
        bus.i_flush = 1'b0;
        check("fl0_count", 32'(bus.o_count), 32'd0);

        // Decode stalled: fill to full, PC held at 0x10.
        for (int i = 0; i < 5; i++) begin
            fetch(32'(4 * i));
            #1;
            check("fill_pc_en", 32'(bus.o_pc_en), (i < 4) ? 32'd1 : 32'd0);
            step();
            check("fill_count", 32'(bus.o_count), (i < 4) ? 32'(i + 1) : 32'd4);
        end
        check("full_head", bus.o_id_pc, 32'h0);

        // Decode resumes: first pop does not push, then 0x10 is accepted.
        bus.i_id_ready = 1'b1;
        #1;
        check("popA_pc_en", 32'(bus.o_pc_en), 32'd0);
        step();
        check("popA_count", 32'(bus.o_count), 32'd3);
        check("popA_head",  bus.o_id_pc,      32'h4);
        check("popB_pc_en", 32'(bus.o_pc_en), 32'd1);
        step();
        check("popB_count", 32'(bus.o_count), 32'd3);
        check("popB_head",  bus.o_id_pc,      32'h8);
        fetch(32'h14);
        step();
        check("popC_head",  bus.o_id_pc,      32'hC);
        fetch(32'h18);
        step();
        check("popD_head",  bus.o_id_pc,      32'h10);
        check("popD_instr", bus.o_id_instr,   instr_of(32'h10));
        check("popD_count", 32'(bus.o_count), 32'd3);

        // Flush with three entries held.
        bus.i_flush    = 1'b1;
        bus.i_id_ready = 1'b0;
        fetch(32'h40);
        #1;
        check("fl3_pc_en", 32'(bus.o_pc_en), 32'd1);
        step();
        bus.i_flush = 1'b0;
        check("fl3_count", 32'(bus.o_count),    32'd0);
        check("fl3_valid", 32'(bus.o_id_valid), 32'd0);
        check("fl3_instr", bus.o_id_instr,      NOP);
        check("fl3_pc",    bus.o_id_pc,         32'h0);

        // Full plus flush plus ready: flush wins.
        for (int i = 0; i < 4; i++) begin
            fetch(32'(32'h40 + 4 * i));
            step();
        end
        check("ff_full", 32'(bus.o_count), 32'd4);
        bus.i_flush    = 1'b1;
        bus.i_id_ready = 1'b1;
        #1;
        check("ff_pc_en", 32'(bus.o_pc_en), 32'd1);
        step();
        bus.i_flush    = 1'b0;
        bus.i_id_ready = 1'b0;
        check("ff_count", 32'(bus.o_count),    32'd0);
        check("ff_valid", 32'(bus.o_id_valid), 32'd0);

        // Steady push/pop at count 2 across pointer wrap.
        fetch(32'h100);
        step();
        fetch(32'h104);
        step();
        check("pp_start", 32'(bus.o_count), 32'd2);
        bus.i_id_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            fetch(32'(32'h108 + 4 * i));
            step();
            exp_pc = 32'(32'h100 + 4 * (i + 1));
            check("pp_count", 32'(bus.o_count), 32'd2);
            check("pp_head",  bus.o_id_pc,      exp_pc);
            check("pp_instr", bus.o_id_instr,   instr_of(exp_pc));
        end

        // Reach three entries, then reset between edges.
        bus.i_id_ready = 1'b0;
        fetch(32'h300);
        step();
        check("ar_pre", 32'(bus.o_count), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_count", 32'(bus.o_count),    32'd0);
        check("ar_valid", 32'(bus.o_id_valid), 32'd0);
        check("ar_instr", bus.o_id_instr,      NOP);
        check("ar_pc_en", 32'(bus.o_pc_en),    32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // After reset the first push becomes the head.
        fetch(32'h200);
        step();
        check("pr_count", 32'(bus.o_count), 32'd1);
        check("pr_head",  bus.o_id_pc,      32'h200);
        fetch(32'h204);
        step();
        check("pr_count2", 32'(bus.o_count), 32'd2);
        check("pr_head2",  bus.o_id_pc,      32'h200);
        bus.i_id_ready = 1'b1;
        fetch(32'h208);
        step();
        check("pr_head3",  bus.o_id_pc,      32'h204);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
